uart_cmd_arbiter: RTL and testbench
===================================

UART_CMD_ARBITER -- requirements
Module: uart_cmd_arbiter

Interface
REQ-001 Parameters SHALL be: CMD_WIDTH, default 16, command word width; READ_WIDTH, default 8, read-data width; TIMEOUT, default 65535, cycles allowed for read-data return (1..65535).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_cmd / m1_cmd  in  CMD_WIDTH  requester command; bit CMD_WIDTH-1 = 1 read, 0 write.
- m0_cmd_vld / m1_cmd_vld  in  1  requester command valid.
- m0_cmd_rdy / m1_cmd_rdy  out  1  command accepted when vld & rdy.
- m0_rd_data / m1_rd_data  out  READ_WIDTH  read result.
- m0_rd_vld / m1_rd_vld  out  1  one-cycle read completion pulse.
- m0_rd_err / m1_rd_err  out  1  qualifies rd_vld; 1 = timeout.
- u_cmd  out  CMD_WIDTH  command to UART controller.
- u_cmd_vld  out  1  command valid to UART controller.
- u_cmd_rdy  in  1  UART controller idle/ready.
- u_read_rdy  in  1  one-cycle read-data-valid pulse from UART controller.
- u_read_data  in  READ_WIDTH  read data from UART controller.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, GUARD, WAIT_DONE, WAIT_READ.
REQ-004 In IDLE, mX_cmd_rdy SHALL be high, combinationally, only for the granted requester; both low in all other states.
REQ-005 Grant SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-grant pointer resets to 1 (m0 wins the first tie).
REQ-006 On accept in IDLE, the arbiter SHALL latch the command and owner ID, then go to ISSUE next cycle.
REQ-007 In ISSUE, u_cmd_vld SHALL be 1 and u_cmd SHALL equal the latched command, held stable until u_cmd_vld & u_cmd_rdy; outside ISSUE, u_cmd_vld SHALL be 0.
REQ-008 On the UART handshake, the FSM SHALL go to GUARD for exactly one cycle, ignoring u_cmd_rdy, then go to WAIT_READ for a read or WAIT_DONE for a write.
REQ-009 WAIT_DONE SHALL return to IDLE on the first cycle u_cmd_rdy = 1.
REQ-010 WAIT_READ SHALL clear a 16-bit timeout counter on entry and increment it each cycle.
REQ-011 In WAIT_READ, when u_read_rdy = 1, the owner's rd_data SHALL load u_read_data and its rd_vld SHALL pulse for one cycle with rd_err = 0 on the next cycle; the FSM SHALL then go to WAIT_DONE.
REQ-012 In WAIT_READ, if the counter reaches TIMEOUT-1 without u_read_rdy, the owner's rd_vld and rd_err SHALL pulse together with rd_data = 0; the FSM SHALL then go to WAIT_DONE.
REQ-013 If u_read_rdy and timeout occur in the same cycle, data SHALL win (rd_err = 0).
REQ-014 u_read_rdy outside WAIT_READ SHALL be ignored; no rd_vld SHALL be produced.
REQ-015 Only the owner's rd_vld/rd_err SHALL ever pulse; the other requester's outputs SHALL stay 0, and its rd_data SHALL hold its last value.
REQ-016 Exactly one command SHALL be outstanding at a time; throughput is at most one command per UART transaction.
REQ-017 Requester vld deasserting while not granted SHALL have no effect; no request is queued internally.

Reset
REQ-018 While rst_n = 0, the FSM SHALL be in IDLE; all rdy, vld, err outputs SHALL be 0; u_cmd, rd_data, the counter and the latched command SHALL be 0; the pointer SHALL be 1.
REQ-019 Reset asserted mid-transaction SHALL abandon it immediately with no rd_vld; after release, operation SHALL resume from IDLE.

Verification
REQ-020 Write from m0: m0_cmd=16'h0155 with vld; UART rdy=1 -> u_cmd=16'h0155 in ISSUE, handshake, GUARD; UART drops rdy 10 cycles, then raises -> IDLE; no rd_vld.
REQ-021 Read from m1: m1_cmd=16'h8023; UART returns u_read_data=8'hA5 pulse -> next cycle m1_rd_data=8'hA5, m1_rd_vld=1 for 1 cycle, m1_rd_err=0; m0 outputs all 0.
REQ-022 Contention: both vld continuously from reset with writes -> grants m0, m1, m0, m1 alternately over 4 transactions.
REQ-023 Timeout: TIMEOUT=20, m0 read, no u_read_rdy -> m0_rd_vld=m0_rd_err=1 exactly 20 cycles after WAIT_READ entry, rd_data=0; FSM then reaches IDLE when u_cmd_rdy=1.
REQ-024 Boundaries: u_read_rdy on the same cycle as the timeout -> rd_err=0 with data; spurious u_read_rdy in IDLE -> no rd_vld.
REQ-025 Reset mid-read: assert rst_n=0 in WAIT_READ -> all outputs 0 asynchronously; after release, a new m1 write completes normally.

Source files
------------

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter
//   Arbitrates two command requesters (m0, m1) onto a single UART controller
//   command port. Grants round-robin, keeps exactly one command in flight,
//   and for reads routes the returned byte (or a timeout error) back to the
//   requester that issued the command.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_cmd / mX_cmd_vld        requester command (MSB = 1 read, 0 write)
//   mX_cmd_rdy                 combinational grant, only in IDLE
//   mX_rd_data/_vld/_err       read completion (one-cycle vld, err = timeout)
//   u_cmd / u_cmd_vld          command presented to the UART controller
//   u_cmd_rdy                  UART controller idle/ready
//   u_read_rdy / u_read_data   read-data-valid pulse and data from UART
module uart_cmd_arbiter #(
  parameter int CMD_WIDTH  = 16,
  parameter int READ_WIDTH = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_WIDTH-1:0]  m0_cmd,
  input  logic                  m0_cmd_vld,
  output logic                  m0_cmd_rdy,
  output logic [READ_WIDTH-1:0] m0_rd_data,
  output logic                  m0_rd_vld,
  output logic                  m0_rd_err,
  input  logic [CMD_WIDTH-1:0]  m1_cmd,
  input  logic                  m1_cmd_vld,
  output logic                  m1_cmd_rdy,
  output logic [READ_WIDTH-1:0] m1_rd_data,
  output logic                  m1_rd_vld,
  output logic                  m1_rd_err,
  output logic [CMD_WIDTH-1:0]  u_cmd,
  output logic                  u_cmd_vld,
  input  logic                  u_cmd_rdy,
  input  logic                  u_read_rdy,
  input  logic [READ_WIDTH-1:0] u_read_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT_DONE, WAIT_READ} state_t;

  // Counter compares against TIMEOUT-1: it is 0 on the first WAIT_READ
  // cycle, so the error pulse lands TIMEOUT cycles after entry.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t               state;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 owner;   // 0 = m0, 1 = m1
  logic                 last;    // requester granted most recently
  logic [15:0]          cnt;
  logic                 gnt0, gnt1;

  // With both requesting, the one not granted last wins. last resets to 1
  // so m0 wins the first tie.
  always_comb begin
    gnt1 = m1_cmd_vld & (~m0_cmd_vld | ~last);
    gnt0 = m0_cmd_vld & ~gnt1;
  end

  // rst_n gating keeps the grants low while reset is held even though the
  // state register already sits in IDLE.
  assign m0_cmd_rdy = rst_n & (state == IDLE) & gnt0;
  assign m1_cmd_rdy = rst_n & (state == IDLE) & gnt1;
  assign u_cmd_vld  = (state == ISSUE);
  assign u_cmd      = cmd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      owner      <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      m0_rd_data <= '0;
      m0_rd_vld  <= 1'b0;
      m0_rd_err  <= 1'b0;
      m1_rd_data <= '0;
      m1_rd_vld  <= 1'b0;
      m1_rd_err  <= 1'b0;
    end else begin
      m0_rd_vld <= 1'b0;
      m0_rd_err <= 1'b0;
      m1_rd_vld <= 1'b0;
      m1_rd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            cmd_q <= gnt1 ? m1_cmd : m0_cmd;
            owner <= gnt1;
            last  <= gnt1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (u_cmd_rdy) state <= GUARD;
        end
        // One dead cycle: the controller's rdy may still read high right
        // after the handshake, before it has gone busy.
        GUARD: begin
          if (cmd_q[CMD_WIDTH-1]) begin
            cnt   <= '0;
            state <= WAIT_READ;
          end else begin
            state <= WAIT_DONE;
          end
        end
        WAIT_READ: begin
          // Data beats the timeout when both land on the same cycle.
          if (u_read_rdy || cnt == TO_LAST) begin
            if (owner) begin
              m1_rd_vld  <= 1'b1;
              m1_rd_err  <= ~u_read_rdy;
              m1_rd_data <= u_read_rdy ? u_read_data : '0;
            end else begin
              m0_rd_vld  <= 1'b1;
              m0_rd_err  <= ~u_read_rdy;
              m0_rd_data <= u_read_rdy ? u_read_data : '0;
            end
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (u_cmd_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Self-checking bench for uart_cmd_arbiter (TIMEOUT = 20).
// Monitors log accepts, UART handshakes and read completions with edge
// numbers; scenario tasks and a randomized transaction-level model check them.
module tb_uart_cmd_arbiter;
  localparam int CW = 16;
  localparam int RW = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] m0_cmd, m1_cmd, u_cmd;
  logic          m0_cmd_vld, m1_cmd_vld, m0_cmd_rdy, m1_cmd_rdy;
  logic [RW-1:0] m0_rd_data, m1_rd_data, u_read_data;
  logic          m0_rd_vld, m0_rd_err, m1_rd_vld, m1_rd_err;
  logic          u_cmd_vld, u_cmd_rdy, u_read_rdy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_arbiter #(.CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd(m0_cmd), .m0_cmd_vld(m0_cmd_vld), .m0_cmd_rdy(m0_cmd_rdy),
    .m0_rd_data(m0_rd_data), .m0_rd_vld(m0_rd_vld), .m0_rd_err(m0_rd_err),
    .m1_cmd(m1_cmd), .m1_cmd_vld(m1_cmd_vld), .m1_cmd_rdy(m1_cmd_rdy),
    .m1_rd_data(m1_rd_data), .m1_rd_vld(m1_rd_vld), .m1_rd_err(m1_rd_err),
    .u_cmd(u_cmd), .u_cmd_vld(u_cmd_vld), .u_cmd_rdy(u_cmd_rdy),
    .u_read_rdy(u_read_rdy), .u_read_data(u_read_data)
  );

  typedef struct {int who; logic [CW-1:0] cmd; int ecyc;} acc_t;
  typedef struct {logic [CW-1:0] cmd; int ecyc;} hs_t;
  typedef struct {int who; logic [RW-1:0] data; logic err; int ecyc;} ev_t;
  acc_t accq[$];
  hs_t  hsq[$];
  ev_t  evq[$];

  // Edge e is logged with cyc_cnt == e; after that edge cyc_cnt == e+1.
  always @(posedge clk) begin
    if (m0_cmd_vld && m0_cmd_rdy) accq.push_back('{0, m0_cmd, cyc_cnt});
    if (m1_cmd_vld && m1_cmd_rdy) accq.push_back('{1, m1_cmd, cyc_cnt});
    if (u_cmd_vld && u_cmd_rdy)   hsq.push_back('{u_cmd, cyc_cnt});
    cyc_cnt <= cyc_cnt + 1;
  end

  always @(negedge clk) begin
    if (m0_rd_vld) evq.push_back('{0, m0_rd_data, m0_rd_err, cyc_cnt - 1});
    if (m1_rd_vld) evq.push_back('{1, m1_rd_data, m1_rd_err, cyc_cnt - 1});
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    accq.delete(); hsq.delete(); evq.delete();
  endtask

  task automatic wait_acc(input int n, output bit ok);
    for (int i = 0; i < 100 && accq.size() < n; i++) cyc();
    ok = (accq.size() >= n);
  endtask

  task automatic wait_hs(input int n, output bit ok);
    for (int i = 0; i < 100 && hsq.size() < n; i++) cyc();
    ok = (hsq.size() >= n);
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    m0_cmd = 16'h1234; m1_cmd = 16'h8765;
    m0_cmd_vld = 1; m1_cmd_vld = 1; u_cmd_rdy = 1; u_read_rdy = 1;
    u_read_data = 8'h5A;
    cyc(2);
    flags = {m0_cmd_rdy, m1_cmd_rdy, u_cmd_vld, m0_rd_vld, m0_rd_err, m1_rd_vld, m1_rd_err};
    checks++;
    if (flags !== 7'd0) begin errors++; $display("FAIL reset_flags: got %b exp 0", flags); end
    checks++;
    if (u_cmd !== 16'd0) begin errors++; $display("FAIL reset_u_cmd: got %h exp 0", u_cmd); end
    checks++;
    if ({m0_rd_data, m1_rd_data} !== 16'd0) begin
      errors++; $display("FAIL reset_rd_data: got %h/%h exp 0", m0_rd_data, m1_rd_data);
    end
    m0_cmd_vld = 0; m1_cmd_vld = 0; u_read_rdy = 0;
    rst_n = 1;
    cyc();
  endtask

  task automatic test_write_m0();
    bit ok, busy_ok;
    int a;
    clear_logs();
    u_cmd_rdy = 1; m0_cmd = 16'h0155; m0_cmd_vld = 1;
    wait_acc(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_accept: got no accept exp accept"); end
    m0_cmd_vld = 0;
    a = accq[0].ecyc;
    checks++;
    if (u_cmd_vld !== 1'b1 || u_cmd !== 16'h0155) begin
      errors++; $display("FAIL wr_issue: got vld %b cmd %h exp 1 0155", u_cmd_vld, u_cmd);
    end
    cyc();
    checks++;
    if (hsq.size() != 1 || hsq[0].cmd !== 16'h0155 || hsq[0].ecyc != a + 1) begin
      errors++; $display("FAIL wr_handshake: got n %0d edge %0d exp n 1 edge %0d", hsq.size(), hsq[0].ecyc, a + 1);
    end
    // Controller goes busy for 10 cycles; nobody may be granted meanwhile.
    u_cmd_rdy = 0; m1_cmd = 16'h0777; m1_cmd_vld = 1;
    busy_ok = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (m1_cmd_rdy !== 1'b0 || u_cmd_vld !== 1'b0) busy_ok = 0;
    end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL wr_busy_hold: got grant/vld while busy exp none"); end
    u_cmd_rdy = 1;
    cyc();
    checks++;
    if (m1_cmd_rdy !== 1'b1) begin errors++; $display("FAIL wr_back_idle: got rdy %b exp 1", m1_cmd_rdy); end
    m1_cmd_vld = 0;
    #1;
    checks++;
    if (evq.size() != 0 || accq.size() != 1 || accq[0].who != 0) begin
      errors++; $display("FAIL wr_side_effects: got ev %0d acc %0d exp 0 1", evq.size(), accq.size());
    end
  endtask

  task automatic test_read_m1();
    bit ok;
    clear_logs();
    u_cmd_rdy = 1; m1_cmd = 16'h8023; m1_cmd_vld = 1;
    wait_acc(1, ok);
    m1_cmd_vld = 0;
    wait_hs(1, ok);
    checks++;
    if (!ok || accq[0].who != 1) begin errors++; $display("FAIL rd_issue: got hs %b exp handshake by m1", ok); end
    cyc(3);
    u_read_data = 8'hA5; u_read_rdy = 1;
    cyc();
    u_read_rdy = 0; u_read_data = 8'h00;
    checks++;
    if (m1_rd_vld !== 1'b1 || m1_rd_err !== 1'b0 || m1_rd_data !== 8'hA5) begin
      errors++; $display("FAIL rd_m1_data: got vld %b err %b data %h exp 1 0 a5", m1_rd_vld, m1_rd_err, m1_rd_data);
    end
    checks++;
    if ({m0_rd_vld, m0_rd_err, m0_rd_data} !== 10'd0) begin
      errors++; $display("FAIL rd_m0_quiet: got %b %b %h exp 0", m0_rd_vld, m0_rd_err, m0_rd_data);
    end
    cyc();
    checks++;
    if (m1_rd_vld !== 1'b0 || evq.size() != 1) begin
      errors++; $display("FAIL rd_one_pulse: got vld %b events %0d exp 0 1", m1_rd_vld, evq.size());
    end
    cyc(2);
  endtask

  task automatic test_contention();
    bit ok;
    rst_n = 0;
    clear_logs();
    m0_cmd = 16'h0011; m1_cmd = 16'h0022; m0_cmd_vld = 1; m1_cmd_vld = 1; u_cmd_rdy = 1;
    cyc();
    rst_n = 1;
    wait_acc(4, ok);
    m0_cmd_vld = 0; m1_cmd_vld = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_accepts: got %0d exp 4", accq.size()); end
    // Pointer starts at m1, so m0 takes the first tie and they alternate.
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (accq[i].who != i % 2) begin errors++; $display("FAIL cont_grant%0d: got m%0d exp m%0d", i, accq[i].who, i % 2); end
    end
    cyc(4);
    checks++;
    if (hsq.size() != 4 || hsq[1].cmd !== 16'h0022 || hsq[2].cmd !== 16'h0011) begin
      errors++; $display("FAIL cont_uart_cmds: got n %0d exp 4 alternating", hsq.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int hs_e, ev_e;
    clear_logs();
    u_cmd_rdy = 1; m0_cmd = 16'h8001; m0_cmd_vld = 1;
    wait_acc(1, ok);
    m0_cmd_vld = 0;
    wait_hs(1, ok);
    hs_e = hsq[0].ecyc;
    for (int i = 0; i < 60 && m0_rd_vld !== 1'b1 && m1_rd_vld !== 1'b1; i++) cyc();
    ev_e = cyc_cnt - 1;
    checks++;
    if (m0_rd_vld !== 1'b1 || m0_rd_err !== 1'b1 || m0_rd_data !== 8'd0 || m1_rd_vld !== 1'b0) begin
      errors++; $display("FAIL to_pulse: got vld %b err %b data %h exp 1 1 00", m0_rd_vld, m0_rd_err, m0_rd_data);
    end
    // WAIT_READ is entered one guard cycle after the handshake edge.
    checks++;
    if (ev_e != hs_e + 1 + TO) begin errors++; $display("FAIL to_latency: got edge %0d exp %0d", ev_e, hs_e + 1 + TO); end
    m1_cmd = 16'h0123; m1_cmd_vld = 1;
    cyc();
    checks++;
    if (m0_rd_vld !== 1'b0 || m0_rd_err !== 1'b0) begin errors++; $display("FAIL to_one_pulse: got %b %b exp 0 0", m0_rd_vld, m0_rd_err); end
    wait_acc(2, ok);
    m1_cmd_vld = 0;
    checks++;
    if (!ok || accq[1].who != 1 || accq[1].ecyc != ev_e + 2) begin
      errors++; $display("FAIL to_next_grant: got edge %0d exp %0d", accq[1].ecyc, ev_e + 2);
    end
    cyc(4);
  endtask

  task automatic test_boundary();
    bit ok;
    int hs_e;
    clear_logs();
    u_cmd_rdy = 1; m1_cmd = 16'h8042; m1_cmd_vld = 1;
    wait_acc(1, ok);
    m1_cmd_vld = 0;
    wait_hs(1, ok);
    hs_e = hsq[0].ecyc;
    while (cyc_cnt < hs_e + 1 + TO) cyc();
    u_read_rdy = 1; u_read_data = 8'h3C;
    cyc();
    u_read_rdy = 0;
    checks++;
    if (m1_rd_vld !== 1'b1 || m1_rd_err !== 1'b0 || m1_rd_data !== 8'h3C || cyc_cnt - 1 != hs_e + 1 + TO) begin
      errors++; $display("FAIL bnd_data_wins: got vld %b err %b data %h exp 1 0 3c", m1_rd_vld, m1_rd_err, m1_rd_data);
    end
    cyc(3);
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      u_read_rdy = 1; u_read_data = 8'($urandom);
      cyc();
    end
    u_read_rdy = 0;
    cyc();
    checks++;
    if (evq.size() != 0 || m1_rd_data !== 8'h3C || m0_rd_data !== 8'h00) begin
      errors++; $display("FAIL bnd_spurious: got ev %0d m1 %h m0 %h exp 0 3c 00", evq.size(), m1_rd_data, m0_rd_data);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    logic [6:0] flags;
    clear_logs();
    u_cmd_rdy = 1; m0_cmd = 16'h8077; m0_cmd_vld = 1;
    wait_acc(1, ok);
    m0_cmd_vld = 0;
    wait_hs(1, ok);
    cyc(5);
    rst_n = 0;
    #1;
    flags = {m0_cmd_rdy, m1_cmd_rdy, u_cmd_vld, m0_rd_vld, m0_rd_err, m1_rd_vld, m1_rd_err};
    checks++;
    if (flags !== 7'd0 || u_cmd !== 16'd0 || m0_rd_data !== 8'd0 || m1_rd_data !== 8'd0) begin
      errors++; $display("FAIL rst_async: got flags %b cmd %h d %h/%h exp 0", flags, u_cmd, m0_rd_data, m1_rd_data);
    end
    u_read_rdy = 1; u_read_data = 8'hEE;
    cyc(3);
    u_read_rdy = 0;
    rst_n = 1;
    cyc(TO + 5);
    checks++;
    if (evq.size() != 0) begin errors++; $display("FAIL rst_no_rdvld: got %0d events exp 0", evq.size()); end
    clear_logs();
    m1_cmd = 16'h0456; m1_cmd_vld = 1;
    wait_acc(1, ok);
    m1_cmd_vld = 0;
    wait_hs(1, ok);
    checks++;
    if (!ok || accq[0].who != 1 || hsq[0].cmd !== 16'h0456) begin
      errors++; $display("FAIL rst_resume: got hs %b cmd %h exp 1 0456", ok, hsq[0].cmd);
    end
    cyc(3);
    m0_cmd_vld = 1;
    #1;
    checks++;
    if (m0_cmd_rdy !== 1'b1 || evq.size() != 0) begin
      errors++; $display("FAIL rst_resume_idle: got rdy %b ev %0d exp 1 0", m0_cmd_rdy, evq.size());
    end
    m0_cmd_vld = 0;
    cyc();
  endtask

  // Transaction-level model: round-robin owner, one outstanding command,
  // read outcome decided by when the data pulse lands relative to entry.
  task automatic test_random();
    bit ok;
    int last, who, v, hs_e, j, exp_e;
    logic [CW-1:0] c0, c1, exp_cmd;
    logic [RW-1:0] d, exp_d;
    logic exp_err;
    logic [RW-1:0] mdl_data [2];
    rst_n = 0; cyc(); rst_n = 1;
    last = 1; mdl_data[0] = '0; mdl_data[1] = '0;
    for (int r = 0; r < 30; r++) begin
      clear_logs();
      v = $urandom_range(1, 3);
      c0 = 16'($urandom); c1 = 16'($urandom);
      who = (v == 3) ? (last == 1 ? 0 : 1) : (v == 1 ? 0 : 1);
      exp_cmd = who ? c1 : c0;
      m0_cmd = c0; m1_cmd = c1;
      m0_cmd_vld = v[0]; m1_cmd_vld = v[1];
      wait_acc(1, ok);
      m0_cmd_vld = 0; m1_cmd_vld = 0;
      checks++;
      if (!ok || accq.size() != 1 || accq[0].who != who || accq[0].cmd !== exp_cmd) begin
        errors++; $display("FAIL rnd%0d_grant: got m%0d %h exp m%0d %h", r, accq[0].who, accq[0].cmd, who, exp_cmd);
      end
      last = who;
      for (int i = 0; i < 50 && hsq.size() < 1; i++) begin
        u_cmd_rdy = 1'($urandom);
        cyc();
      end
      checks++;
      if (hsq.size() != 1 || hsq[0].cmd !== exp_cmd) begin
        errors++; $display("FAIL rnd%0d_uart: got n %0d cmd %h exp 1 %h", r, hsq.size(), hsq[0].cmd, exp_cmd);
      end
      hs_e = hsq[0].ecyc;
      if (exp_cmd[CW-1]) begin
        j = $urandom_range(1, TO + 3);
        d = 8'($urandom);
        while (cyc_cnt < hs_e + 1 + j) cyc();
        u_read_rdy = 1; u_read_data = d;
        cyc();
        u_read_rdy = 0;
        u_cmd_rdy = 1;
        cyc(3);
        if (j <= TO) begin exp_d = d;  exp_err = 0; exp_e = hs_e + 1 + j;  end
        else         begin exp_d = '0; exp_err = 1; exp_e = hs_e + 1 + TO; end
        mdl_data[who] = exp_d;
        checks++;
        if (evq.size() != 1 || evq[0].who != who || evq[0].data !== exp_d ||
            evq[0].err !== exp_err || evq[0].ecyc != exp_e) begin
          errors++;
          $display("FAIL rnd%0d_read: got n %0d m%0d %h err %b edge %0d exp m%0d %h err %b edge %0d",
                   r, evq.size(), evq[0].who, evq[0].data, evq[0].err, evq[0].ecyc, who, exp_d, exp_err, exp_e);
        end
      end else begin
        for (int i = 0; i < 3; i++) begin u_cmd_rdy = 1'($urandom); cyc(); end
        u_cmd_rdy = 1;
        cyc(3);
        checks++;
        if (evq.size() != 0) begin errors++; $display("FAIL rnd%0d_write_quiet: got %0d events exp 0", r, evq.size()); end
      end
      checks++;
      if (m0_rd_data !== mdl_data[0] || m1_rd_data !== mdl_data[1]) begin
        errors++; $display("FAIL rnd%0d_hold: got %h/%h exp %h/%h", r, m0_rd_data, m1_rd_data, mdl_data[0], mdl_data[1]);
      end
    end
  endtask

  initial begin
    rst_n = 1;
    m0_cmd = '0; m1_cmd = '0; m0_cmd_vld = 0; m1_cmd_vld = 0;
    u_cmd_rdy = 0; u_read_rdy = 0; u_read_data = '0;
    #1 rst_n = 0;
    test_reset();
    test_write_m0();
    test_read_m1();
    test_contention();
    test_timeout();
    test_boundary();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
